// File: rtl/cube_face_sampler_if.sv
// Pixel FIFO read port and facelet result burst of cube_face_sampler.
// The slave modport is the sampler's view; master is the FIFO/classifier side.
interface cube_face_sampler_if;
    logic        frame_start;
    logic        d_available;
    logic [15:0] r_data;
    logic        r_en;
    logic        res_valid;
    logic [3:0]  res_idx;
    logic [15:0] res_rgb;
    logic        frame_err;

    modport slave (
        input  frame_start, d_available, r_data,
        output r_en, res_valid, res_idx, res_rgb, frame_err
    );

    modport master (
        output frame_start, d_available, r_data,
        input  r_en, res_valid, res_idx, res_rgb, frame_err
    );
endinterface

// File: rtl/cube_face_sampler.sv
// Averages RGB565 colour over nine fixed facelet windows of one camera frame
// and emits the nine averages as an indexed burst at frame end.
module cube_face_sampler #(
    parameter int unsigned IMG_W      = 320,
    parameter int unsigned IMG_H      = 240,
    parameter int unsigned WIN_LOG2   = 4,
    parameter int unsigned GRID_X0    = 96,
    parameter int unsigned GRID_Y0    = 56,
    parameter int unsigned CELL_PITCH = 64
) (
    input logic                clk_25MHz,
    input logic                rst_n,
    cube_face_sampler_if.slave bus
);
    localparam int unsigned WIN  = 1 << WIN_LOG2;
    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned NWIN = 9;
    localparam int unsigned X_W  = $clog2(IMG_W);
    localparam int unsigned Y_W  = $clog2(IMG_H);
    localparam int unsigned N_W  = $clog2(NPIX + 1);
    localparam int unsigned RB_W = 5 + 2 * WIN_LOG2;
    localparam int unsigned G_W  = 6 + 2 * WIN_LOG2;

    typedef enum logic [1:0] {IDLE, ACTIVE, EMIT} state_t;

    state_t          state;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [N_W-1:0]  issued;
    logic            rd_pend;
    logic            pending;
    logic [3:0]      emit_idx;
    logic [RB_W-1:0] acc_r [NWIN];
    logic [G_W-1:0]  acc_g [NWIN];
    logic [RB_W-1:0] acc_b [NWIN];

    logic [2:0]      col_hit;
    logic [2:0]      row_hit;
    logic            in_win;
    logic [3:0]      win_k;
    logic            last_pix;
    logic            r_en_c;
    logic            clear_c;
    logic [RB_W-1:0] sum0_r;
    logic [G_W-1:0]  sum0_g;
    logic [RB_W-1:0] sum0_b;

    function automatic logic [15:0] avg_rgb(input logic [RB_W-1:0] r,
                                            input logic [G_W-1:0]  g,
                                            input logic [RB_W-1:0] b);
        return {r[RB_W-1 -: 5], g[G_W-1 -: 6], b[RB_W-1 -: 5]};
    endfunction

    // Row/column membership of the current pixel coordinate
    always_comb begin
        col_hit = '0;
        row_hit = '0;
        for (int i = 0; i < 3; i++) begin
            col_hit[i] = (x >= X_W'(GRID_X0 + i * CELL_PITCH)) &&
                         (x <= X_W'(GRID_X0 + i * CELL_PITCH + WIN - 1));
            row_hit[i] = (y >= Y_W'(GRID_Y0 + i * CELL_PITCH)) &&
                         (y <= Y_W'(GRID_Y0 + i * CELL_PITCH + WIN - 1));
        end
    end

    always_comb begin
        in_win = (|col_hit) && (|row_hit);
        win_k  = '0;
        for (int ri = 0; ri < 3; ri++) begin
            for (int ci = 0; ci < 3; ci++) begin
                if (row_hit[ri] && col_hit[ci]) begin
                    win_k = 4'(3 * ri + ci);
                end
            end
        end
    end

    assign last_pix = (x == X_W'(IMG_W - 1)) && (y == Y_W'(IMG_H - 1));
    assign r_en_c   = (state == ACTIVE) && bus.d_available && (issued < N_W'(NPIX));
    assign bus.r_en = r_en_c;

    // Frame (re)start: from IDLE, abort in ACTIVE, or deferred start at burst end
    always_comb begin
        clear_c = 1'b0;
        case (state)
            IDLE, ACTIVE: clear_c = bus.frame_start;
            EMIT:         clear_c = (emit_idx == 4'(NWIN)) && (pending || bus.frame_start);
            default:      clear_c = 1'b0;
        endcase
    end

    // Beat 0 leaves on the same edge as the final pixel, so fold that pixel in
    always_comb begin
        sum0_r = acc_r[0];
        sum0_g = acc_g[0];
        sum0_b = acc_b[0];
        if (rd_pend && in_win && (win_k == 4'd0)) begin
            sum0_r = acc_r[0] + RB_W'(bus.r_data[15:11]);
            sum0_g = acc_g[0] + G_W'(bus.r_data[10:5]);
            sum0_b = acc_b[0] + RB_W'(bus.r_data[4:0]);
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            issued        <= '0;
            rd_pend       <= 1'b0;
            pending       <= 1'b0;
            emit_idx      <= '0;
            bus.res_valid <= 1'b0;
            bus.res_idx   <= '0;
            bus.res_rgb   <= '0;
            bus.frame_err <= 1'b0;
            for (int k = 0; k < NWIN; k++) begin
                acc_r[k] <= '0;
                acc_g[k] <= '0;
                acc_b[k] <= '0;
            end
        end else begin
            bus.res_valid <= 1'b0;
            bus.frame_err <= 1'b0;
            rd_pend       <= r_en_c;

            case (state)
                IDLE: begin
                    if (bus.frame_start) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (bus.frame_start) begin
                        bus.frame_err <= 1'b1;
                    end else begin
                        if (r_en_c) issued <= issued + N_W'(1);
                        if (rd_pend) begin
                            if (in_win) begin
                                acc_r[win_k] <= acc_r[win_k] + RB_W'(bus.r_data[15:11]);
                                acc_g[win_k] <= acc_g[win_k] + G_W'(bus.r_data[10:5]);
                                acc_b[win_k] <= acc_b[win_k] + RB_W'(bus.r_data[4:0]);
                            end
                            if (x == X_W'(IMG_W - 1)) begin
                                x <= '0;
                                y <= y + Y_W'(1);
                            end else begin
                                x <= x + X_W'(1);
                            end
                            if (last_pix) begin
                                state         <= EMIT;
                                emit_idx      <= 4'd1;
                                bus.res_valid <= 1'b1;
                                bus.res_idx   <= 4'd0;
                                bus.res_rgb   <= avg_rgb(sum0_r, sum0_g, sum0_b);
                            end
                        end
                    end
                end
                EMIT: begin
                    if (bus.frame_start) pending <= 1'b1;
                    if (emit_idx < 4'(NWIN)) begin
                        bus.res_valid <= 1'b1;
                        bus.res_idx   <= emit_idx;
                        bus.res_rgb   <= avg_rgb(acc_r[emit_idx], acc_g[emit_idx], acc_b[emit_idx]);
                        emit_idx      <= emit_idx + 4'd1;
                    end else begin
                        pending <= 1'b0;
                        state   <= (pending || bus.frame_start) ? ACTIVE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Start of a fresh frame; any read still in flight is dropped
            if (clear_c) begin
                x       <= '0;
                y       <= '0;
                issued  <= '0;
                rd_pend <= 1'b0;
                for (int k = 0; k < NWIN; k++) begin
                    acc_r[k] <= '0;
                    acc_g[k] <= '0;
                    acc_b[k] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cube_face_sampler.sv
// Self-checking bench for cube_face_sampler on a reduced 32x24 frame with
// 4x4 windows; a FIFO model feeds pixels and a scoreboard holds expected beats.
module tb_cube_face_sampler;
    localparam int IMG_W      = 32;
    localparam int IMG_H      = 24;
    localparam int WIN_LOG2   = 2;
    localparam int GRID_X0    = 5;
    localparam int GRID_Y0    = 3;
    localparam int CELL_PITCH = 8;
    localparam int NPIX       = IMG_W * IMG_H;
    localparam int WIN        = 1 << WIN_LOG2;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] rgb;
    } beat_t;

    logic clk;
    logic rst_n;

    cube_face_sampler_if bus();

    cube_face_sampler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN_LOG2(WIN_LOG2),
        .GRID_X0(GRID_X0), .GRID_Y0(GRID_Y0), .CELL_PITCH(CELL_PITCH)
    ) dut (
        .clk_25MHz(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int checks;
    int errors;
    int cyc;
    int pat;
    logic [15:0] fill;
    logic [15:0] next_fill;
    int rand_avail;
    int src_x, src_y, reads;
    logic [15:0] pend_pix;
    bit pend_valid;
    bit fs_req;
    int fs_on_beat;
    int fs_cyc;
    int beats, first_beat_cyc, last_beat_cyc, last_read_cyc;
    int err_pulses, err_cyc, ren_viol, first_ren_cyc;
    beat_t exp_q[$];
    beat_t obs_q[$];

    function automatic beat_t mk_beat(input int k, input logic [15:0] rgb);
        beat_t b;
        b.idx = 4'(k);
        b.rgb = rgb;
        return b;
    endfunction

    function automatic int win_of(input int px, input int py);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (px >= GRID_X0 + c * CELL_PITCH && px < GRID_X0 + c * CELL_PITCH + WIN &&
                    py >= GRID_Y0 + r * CELL_PITCH && py < GRID_Y0 + r * CELL_PITCH + WIN)
                    return 3 * r + c;
            end
        end
        return -1;
    endfunction

    function automatic logic [15:0] pix_at(input int px, input int py);
        int k;
        case (pat)
            0: return fill;
            1: begin
                k = win_of(px, py);
                return (k < 0) ? 16'hFFFF : 16'(16'h0841 * k);
            end
            default: return {5'(px), 6'(py), 5'(px ^ py)};
        endcase
    endfunction

    task automatic reset_obs();
        beats = 0; first_beat_cyc = -1; last_beat_cyc = -1; last_read_cyc = -1;
        err_pulses = 0; err_cyc = -1; ren_viol = 0; first_ren_cyc = -1;
        fs_cyc = -1; fs_on_beat = -1; reads = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    // One clock cycle: record outputs, drive FIFO side, note reads
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.res_valid) begin
            obs_q.push_back(mk_beat(int'(bus.res_idx), bus.res_rgb));
            if (beats == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            beats++;
        end
        if (bus.frame_err) begin
            err_pulses++;
            err_cyc = cyc;
        end
        bus.r_data = pend_valid ? pend_pix : 16'h5A5A;
        pend_valid = 1'b0;
        bus.frame_start = 1'b0;
        if (fs_req || (fs_on_beat >= 0 && bus.res_valid && int'(bus.res_idx) == fs_on_beat)) begin
            bus.frame_start = 1'b1;
            fs_cyc = cyc;
            fs_req = 1'b0;
            fs_on_beat = -1;
            src_x = 0; src_y = 0; reads = 0;
            first_ren_cyc = -1;
            fill = next_fill;
        end
        bus.d_available = bus.frame_start ? 1'b0 :
                          (rand_avail != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (bus.r_en && !bus.d_available) ren_viol++;
        if (bus.r_en && rst_n) begin
            if (first_ren_cyc < 0) first_ren_cyc = cyc;
            pend_pix = pix_at(src_x, src_y);
            pend_valid = 1'b1;
            reads++;
            if (reads == NPIX) last_read_cyc = cyc;
            if (src_x == IMG_W - 1) begin src_x = 0; src_y++; end
            else src_x++;
        end
    endtask

    task automatic start_frame(input logic [15:0] f);
        next_fill = f;
        fs_req = 1'b1;
        step();
    endtask

    task automatic run_until_beats(input int n, input int budget);
        int b;
        b = budget;
        while (beats < n && b > 0) begin
            step();
            b--;
        end
    endtask

    task automatic test_reset();
        beat_t o, e;
        rst_n = 1'b0;
        bus.frame_start = 1'b0; bus.d_available = 1'b1; bus.r_data = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en got %b expected 0", bus.r_en); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b expected 0", bus.res_valid); end
        checks++; if (bus.res_idx !== 4'd0) begin errors++; $display("FAIL reset_res_idx got %0d expected 0", bus.res_idx); end
        checks++; if (bus.res_rgb !== 16'h0000) begin errors++; $display("FAIL reset_res_rgb got %h expected 0000", bus.res_rgb); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b expected 0", bus.frame_err); end
        rst_n = 1'b1;
        reset_obs();
        repeat (4) step();
        checks++; if (reads !== 0) begin errors++; $display("FAIL idle_no_read got %0d reads expected 0", reads); end
        checks++; if (beats !== 0) begin errors++; $display("FAIL idle_no_burst got %0d beats expected 0", beats); end
    endtask

    task automatic test_uniform();
        beat_t o, e;
        reset_obs(); pat = 0; rand_avail = 0;
        for (int k = 0; k < 9; k++) exp_q.push_back(mk_beat(k, 16'hF800));
        start_frame(16'hF800);
        run_until_beats(9, 2 * NPIX);
        repeat (4) step();
        checks++; if (beats !== 9) begin errors++; $display("FAIL uniform_beats got %0d expected 9", beats); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL uniform_beat missing idx %0d", e.idx); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL uniform_beat got idx %0d rgb %h expected idx %0d rgb %h", o.idx, o.rgb, e.idx, e.rgb); end
            end
        end
        checks++; if (first_beat_cyc !== last_read_cyc + 2) begin errors++; $display("FAIL uniform_latency got cycle %0d expected %0d", first_beat_cyc, last_read_cyc + 2); end
        checks++; if (last_beat_cyc !== first_beat_cyc + 8) begin errors++; $display("FAIL uniform_burst_len got last %0d expected %0d", last_beat_cyc, first_beat_cyc + 8); end
        checks++; if (reads !== NPIX) begin errors++; $display("FAIL uniform_reads got %0d expected %0d", reads, NPIX); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL uniform_frame_err got %0d expected 0", err_pulses); end
    endtask

    task automatic test_window_pattern(input int randomise);
        beat_t o, e;
        reset_obs(); pat = 1; rand_avail = randomise;
        for (int k = 0; k < 9; k++) exp_q.push_back(mk_beat(k, 16'(16'h0841 * k)));
        start_frame(16'h0000);
        run_until_beats(9, 5 * NPIX);
        repeat (2) step();
        checks++; if (beats !== 9) begin errors++; $display("FAIL window_beats rand=%0d got %0d expected 9", randomise, beats); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL window_beat rand=%0d missing idx %0d", randomise, e.idx); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL window_beat rand=%0d got idx %0d rgb %h expected idx %0d rgb %h", randomise, o.idx, o.rgb, e.idx, e.rgb); end
            end
        end
        checks++; if (reads !== NPIX) begin errors++; $display("FAIL window_reads rand=%0d got %0d expected %0d", randomise, reads, NPIX); end
        checks++; if (ren_viol !== 0) begin errors++; $display("FAIL window_ren_stall rand=%0d got %0d violations expected 0", randomise, ren_viol); end
    endtask

    task automatic test_gradient();
        beat_t o, e;
        int sr, sg, sb, x0, y0;
        logic [15:0] p;
        reset_obs(); pat = 2; rand_avail = 0;
        for (int k = 0; k < 9; k++) begin
            sr = 0; sg = 0; sb = 0;
            x0 = GRID_X0 + (k % 3) * CELL_PITCH;
            y0 = GRID_Y0 + (k / 3) * CELL_PITCH;
            for (int yy = y0; yy < y0 + WIN; yy++) begin
                for (int xx = x0; xx < x0 + WIN; xx++) begin
                    p = pix_at(xx, yy);
                    sr += int'(p[15:11]); sg += int'(p[10:5]); sb += int'(p[4:0]);
                end
            end
            exp_q.push_back(mk_beat(k, {5'(sr >> (2 * WIN_LOG2)), 6'(sg >> (2 * WIN_LOG2)), 5'(sb >> (2 * WIN_LOG2))}));
        end
        start_frame(16'h0000);
        run_until_beats(9, 2 * NPIX);
        checks++; if (beats !== 9) begin errors++; $display("FAIL gradient_beats got %0d expected 9", beats); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL gradient_beat missing idx %0d", e.idx); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL gradient_beat got idx %0d rgb %h expected idx %0d rgb %h", o.idx, o.rgb, e.idx, e.rgb); end
            end
        end
    endtask

    task automatic test_abort();
        beat_t o, e;
        int b;
        reset_obs(); pat = 0; rand_avail = 0;
        for (int k = 0; k < 9; k++) exp_q.push_back(mk_beat(k, 16'h001F));
        start_frame(16'hFFFF);
        b = 2 * NPIX;
        while (reads < NPIX / 2 && b > 0) begin step(); b--; end
        start_frame(16'h001F);
        run_until_beats(9, 2 * NPIX);
        repeat (2) step();
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL abort_err_count got %0d expected 1", err_pulses); end
        checks++; if (err_cyc !== fs_cyc + 1) begin errors++; $display("FAIL abort_err_timing got cycle %0d expected %0d", err_cyc, fs_cyc + 1); end
        checks++; if (reads !== NPIX) begin errors++; $display("FAIL abort_reads got %0d expected %0d", reads, NPIX); end
        checks++; if (beats !== 9) begin errors++; $display("FAIL abort_beats got %0d expected 9", beats); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL abort_beat missing idx %0d", e.idx); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL abort_beat got idx %0d rgb %h expected idx %0d rgb %h", o.idx, o.rgb, e.idx, e.rgb); end
            end
        end
    endtask

    task automatic test_emit_restart();
        beat_t o, e;
        int b1_first, b1_last;
        reset_obs(); pat = 0; rand_avail = 0;
        for (int k = 0; k < 9; k++) exp_q.push_back(mk_beat(k, 16'hF800));
        for (int k = 0; k < 9; k++) exp_q.push_back(mk_beat(k, 16'h001F));
        start_frame(16'hF800);
        next_fill = 16'h001F;
        fs_on_beat = 4;
        run_until_beats(9, 2 * NPIX);
        repeat (2) step();
        b1_first = first_beat_cyc;
        b1_last = last_beat_cyc;
        checks++; if (fs_cyc !== b1_first + 4) begin errors++; $display("FAIL emit_start_beat got cycle %0d expected %0d", fs_cyc, b1_first + 4); end
        checks++; if (b1_last !== b1_first + 8) begin errors++; $display("FAIL emit_burst_len got last %0d expected %0d", b1_last, b1_first + 8); end
        checks++; if (first_ren_cyc !== b1_last + 1) begin errors++; $display("FAIL emit_restart_ren got cycle %0d expected %0d", first_ren_cyc, b1_last + 1); end
        run_until_beats(18, 2 * NPIX);
        checks++; if (beats !== 18) begin errors++; $display("FAIL emit_beats got %0d expected 18", beats); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL emit_frame_err got %0d expected 0", err_pulses); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL emit_beat missing idx %0d", e.idx); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL emit_beat got idx %0d rgb %h expected idx %0d rgb %h", o.idx, o.rgb, e.idx, e.rgb); end
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_t o, e;
        reset_obs(); pat = 0; rand_avail = 0;
        start_frame(16'hFFFF);
        repeat (300) step();
        @(negedge clk);
        rst_n = 1'b0;
        pend_valid = 1'b0;
        #1;
        checks++; if (bus.r_en !== 1'b0) begin errors++; $display("FAIL midrst_r_en got %b expected 0", bus.r_en); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL midrst_res_valid got %b expected 0", bus.res_valid); end
        checks++; if (bus.res_idx !== 4'd0 || bus.res_rgb !== 16'h0000) begin errors++; $display("FAIL midrst_res got idx %0d rgb %h expected 0 0000", bus.res_idx, bus.res_rgb); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err got %b expected 0", bus.frame_err); end
        reads = 0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        checks++; if (reads !== 0) begin errors++; $display("FAIL midrst_idle_reads got %0d expected 0", reads); end
        checks++; if (beats !== 0) begin errors++; $display("FAIL midrst_no_burst got %0d beats expected 0", beats); end
        for (int k = 0; k < 9; k++) exp_q.push_back(mk_beat(k, 16'h07E0));
        start_frame(16'h07E0);
        run_until_beats(9, 2 * NPIX);
        checks++; if (beats !== 9) begin errors++; $display("FAIL midrst_beats got %0d expected 9", beats); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL midrst_beat missing idx %0d", e.idx); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL midrst_beat got idx %0d rgb %h expected idx %0d rgb %h", o.idx, o.rgb, e.idx, e.rgb); end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        pat = 0; fill = 16'h0000; next_fill = 16'h0000; rand_avail = 0;
        src_x = 0; src_y = 0; pend_pix = '0; pend_valid = 1'b0; fs_req = 1'b0;
        bus.frame_start = 1'b0; bus.d_available = 1'b0; bus.r_data = '0;
        reset_obs();
        test_reset();
        test_uniform();
        test_window_pattern(0);
        test_window_pattern(1);
        test_gradient();
        test_abort();
        test_emit_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
